// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo-N counter: direction encodings and default parameter values.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 10;
  localparam int DEF_WRAP_W  = 8;

endpackage

// File: rtl/mod_n_counter_if.sv
// Control/status bundle of the modulo-N counter; the master drives commands, the counter is the slave.
interface mod_n_counter_if
  import mod_counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
);

  logic              En;
  logic              Up;
  logic              Load;
  logic [WIDTH-1:0]  D;
  logic [WIDTH-1:0]  B;
  logic              Q;
  logic [WRAP_W-1:0] Wraps;
  logic              Err;

  modport master (
    output En, Up, Load, D,
    input  B, Q, Wraps, Err
  );

  modport slave (
    input  En, Up, Load, D,
    output B, Q, Wraps, Err
  );

endinterface

// File: rtl/mod_n_tc_detect.sv
// Combinational terminal-count detector: flags that the next enabled edge wraps the count.
module mod_n_tc_detect
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] B,
  input  logic             Up,
  input  logic             En,
  output logic             wrap_next
);

  // Compared one bit wider so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = MOD_X - (WIDTH+1)'(1);

  logic [WIDTH:0] b_x;

  always_comb begin
    b_x       = {1'b0, B};
    wrap_next = 1'b0;
    if (En) begin
      if (Up == DIR_UP) wrap_next = (b_x == MAX_X);
      else              wrap_next = (b_x == '0);
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Up/down modulo-N counter with parallel load, registered wrap pulse, saturating wrap count
// and sticky illegal-load flag.
module mod_n_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS,
  parameter int WRAP_W  = DEF_WRAP_W
) (
  input  logic           Store,
  input  logic           Reset,
  mod_n_counter_if.slave bus
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
  endgenerate

  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] MAX_X = MOD_X - ONE_X;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + WRAP_W'(1);
  endfunction

  logic [WIDTH-1:0]  b_q, b_d;
  logic              q_q, q_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              err_q, err_d;
  logic              wrap_next;
  logic [WIDTH:0]    b_x, d_x;

  mod_n_tc_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc_detect (
    .B         (b_q),
    .Up        (bus.Up),
    .En        (bus.En),
    .wrap_next (wrap_next)
  );

  always_comb begin
    b_d     = b_q;
    q_d     = 1'b0;
    wraps_d = wraps_q;
    err_d   = err_q;
    b_x     = {1'b0, b_q};
    d_x     = {1'b0, bus.D};
    if (bus.Load) begin
      if (d_x < MOD_X) begin
        b_d = bus.D;
      end else begin
        b_d   = '0;
        err_d = 1'b1;
      end
    end else if (bus.En) begin
      q_d = wrap_next;
      if (wrap_next) wraps_d = sat_inc(wraps_q);
      // Up-wrap to zero coincides with natural overflow when MODULUS = 2**WIDTH.
      if (bus.Up == DIR_UP) b_d = wrap_next ? '0 : WIDTH'(b_x + ONE_X);
      else                  b_d = wrap_next ? MAX_X[WIDTH-1:0] : WIDTH'(b_x - ONE_X);
    end
  end

  always_ff @(posedge Store or posedge Reset) begin
    if (Reset) begin
      b_q     <= '0;
      q_q     <= 1'b0;
      wraps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      b_q     <= b_d;
      q_q     <= q_d;
      wraps_q <= wraps_d;
      err_q   <= err_d;
    end
  end

  assign bus.B     = b_q;
  assign bus.Q     = q_q;
  assign bus.Wraps = wraps_q;
  assign bus.Err   = err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter at WIDTH=4, MODULUS=10, WRAP_W=8.
module tb_mod_n_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
  localparam int WRAP_W  = 8;

  logic Store;
  logic Reset;
  int   checks;
  int   errors;

  mod_n_counter_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  mod_n_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .WRAP_W  (WRAP_W)
  ) dut (
    .Store (Store),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Store = 1'b0;
  always #5 Store = ~Store;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Store);
    #1;
  endtask

  task automatic check_all(input string tag, input int b, input int q, input int w, input int e);
    check({tag, ".B"},     32'(bus.B),     32'(b));
    check({tag, ".Q"},     32'(bus.Q),     32'(q));
    check({tag, ".Wraps"}, 32'(bus.Wraps), 32'(w));
    check({tag, ".Err"},   32'(bus.Err),   32'(e));
  endtask

  initial begin
    int exp_b;
    int exp_w;
    checks    = 0;
    errors    = 0;
    Reset     = 1'b1;
    bus.En    = 1'b0;
    bus.Up    = 1'b1;
    bus.Load  = 1'b0;
    bus.D     = '0;

    // Reset state, then release between edges; release alone must not pulse Q.
    #12;
    check_all("reset", 0, 0, 0, 0);
    Reset = 1'b0;
    #1;
    check("release_q", 32'(bus.Q), 0);

    // Count up 12 edges: 1..9,0,1,2 with Q only when B returns to 0.
    bus.En = 1'b1;
    bus.Up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("up%0d.B", i), 32'(bus.B), 32'((i + 1) % 10));
      check($sformatf("up%0d.Q", i), 32'(bus.Q), (i == 9) ? 32'd1 : 32'd0);
    end
    check("up12.Wraps", 32'(bus.Wraps), 1);

    // Load 0, then count down across the zero boundary.
    bus.Load = 1'b1;
    bus.D    = 4'd0;
    step();
    check_all("load0", 0, 0, 1, 0);
    bus.Load = 1'b0;
    bus.Up   = 1'b0;
    step();
    check_all("down_wrap", 9, 1, 2, 0);
    step();
    check_all("down_8", 8, 0, 2, 0);

    // Load beats En on the same edge.
    bus.Load = 1'b1;
    bus.D    = 4'd7;
    bus.Up   = 1'b1;
    step();
    check_all("load7", 7, 0, 2, 0);

    // Largest legal load value, then an up edge wraps it.
    bus.D = 4'd9;
    step();
    check_all("load9", 9, 0, 2, 0);
    bus.Load = 1'b0;
    step();
    check_all("load9_wrap", 0, 1, 3, 0);

    // Illegal load clears B and sets the sticky flag.
    bus.Load = 1'b1;
    bus.D    = 4'd12;
    step();
    check_all("load12", 0, 0, 3, 1);
    bus.D = 4'd10;
    step();
    check_all("load10", 0, 0, 3, 1);
    bus.Load = 1'b0;

    // Twenty more counting edges keep Err set.
    for (int i = 0; i < 20; i++) step();
    check_all("err_sticky", 0, 1, 5, 1);

    // Long up-count: Wraps saturates at 255 while Q keeps pulsing.
    exp_b = 0;
    exp_w = 5;
    for (int i = 0; i < 2600; i++) begin
      step();
      exp_b = (exp_b + 1) % 10;
      if (exp_b == 0 && exp_w < 255) exp_w++;
      if (i >= 2560) begin
        check($sformatf("sat%0d.B", i), 32'(bus.B), 32'(exp_b));
        check($sformatf("sat%0d.Q", i), 32'(bus.Q), (exp_b == 0) ? 32'd1 : 32'd0);
      end
    end
    check_all("saturated", 0, 1, 255, 1);

    // Hold: B, Wraps, Err kept, Q dropped.
    bus.En = 1'b0;
    step();
    check_all("hold", 0, 0, 255, 1);

    // Direction change takes effect on the very next edge.
    bus.En = 1'b1;
    bus.Up = 1'b0;
    step();
    check_all("dir_down", 9, 1, 255, 1);
    bus.Up = 1'b1;
    step();
    check_all("dir_up", 0, 1, 255, 1);

    // Fresh run to B=5, Wraps=3 with Err set, then asynchronous reset between edges.
    bus.En = 1'b0;
    Reset  = 1'b1;
    #3;
    Reset = 1'b0;
    bus.Load = 1'b1;
    bus.D    = 4'd15;
    step();
    check_all("prep_err", 0, 0, 0, 1);
    bus.Load = 1'b0;
    bus.En   = 1'b1;
    for (int i = 0; i < 35; i++) step();
    check_all("pre_reset", 5, 0, 3, 1);
    #2;
    Reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0);

    // Reset held across an enabled load edge discards that update.
    bus.Load = 1'b1;
    bus.D    = 4'd6;
    step();
    check_all("reset_held", 0, 0, 0, 0);
    bus.Load = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check("release2_q", 32'(bus.Q), 0);
    step();
    check_all("first_edge", 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
